alu_ctl: RTL and testbench

ALU control decoder for the single-cycle/pipelined MIPS datapath. It combines the 2-bit `ALUop` from the main control unit with the 6-bit R-type `func` field and produces:
- the 4-bit ALU operation select;
- `add` / `sub` strobes that mark signed add/subtract operations for overflow detection;
- an `illegal` flag.

All outputs are registered.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_ctl_decode.sv | 60 ++++++
 rtl/alu_ctl.sv | 45 ++++
 tb/tb_alu_ctl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder:
// ALUop classes, R-type func values and ALUCtl operation codes.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNC_ADD  = 6'd32;
    localparam logic [5:0] FUNC_ADDU = 6'd33;
    localparam logic [5:0] FUNC_SUB  = 6'd34;
    localparam logic [5:0] FUNC_SUBU = 6'd35;
    localparam logic [5:0] FUNC_AND  = 6'd36;
    localparam logic [5:0] FUNC_OR   = 6'd37;
    localparam logic [5:0] FUNC_XOR  = 6'd38;
    localparam logic [5:0] FUNC_NOR  = 6'd39;
    localparam logic [5:0] FUNC_SLT  = 6'd42;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_XOR = 4'b0011;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_INV = 4'b1111;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUop/func decode into ALU operation select,
// signed add/sub strobes and an illegal-combination flag.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUop,
    input  logic [5:0] func,
    output logic [3:0] ALUCtl,
    output logic       add,
    output logic       sub,
    output logic       illegal
);

    // Start from the illegal encoding; only recognised cases clear it.
    always_comb begin
        ALUCtl  = CTL_INV;
        add     = 1'b0;
        sub     = 1'b0;
        illegal = 1'b1;
        case (ALUop)
            ALUOP_ADD: begin
                ALUCtl  = CTL_ADD;
                add     = 1'b1;
                illegal = 1'b0;
            end
            ALUOP_SUB: begin
                ALUCtl  = CTL_SUB;
                sub     = 1'b1;
                illegal = 1'b0;
            end
            ALUOP_RTYPE: begin
                illegal = 1'b0;
                case (func)
                    FUNC_ADD: begin
                        ALUCtl = CTL_ADD;
                        add    = 1'b1;
                    end
                    FUNC_ADDU: ALUCtl = CTL_ADD;
                    FUNC_SUB: begin
                        ALUCtl = CTL_SUB;
                        sub    = 1'b1;
                    end
                    FUNC_SUBU: ALUCtl = CTL_SUB;
                    FUNC_AND:  ALUCtl = CTL_AND;
                    FUNC_OR:   ALUCtl = CTL_OR;
                    FUNC_XOR:  ALUCtl = CTL_XOR;
                    FUNC_NOR:  ALUCtl = CTL_NOR;
                    FUNC_SLT:  ALUCtl = CTL_SLT;
                    default: begin
                        ALUCtl  = CTL_INV;
                        illegal = 1'b1;
                    end
                endcase
            end
            ALUOP_RSVD: illegal = 1'b1;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctl.sv
// ALU control top: decode followed by one output register stage
// with synchronous active-high reset.
module alu_ctl
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ALUop,
    input  logic [5:0] func,
    output logic [3:0] ALUCtl,
    output logic       add,
    output logic       sub,
    output logic       illegal
);

    logic [3:0] ctl_d;
    logic       add_d;
    logic       sub_d;
    logic       illegal_d;

    alu_ctl_decode u_decode (
        .ALUop   (ALUop),
        .func    (func),
        .ALUCtl  (ctl_d),
        .add     (add_d),
        .sub     (sub_d),
        .illegal (illegal_d)
    );

    // Register the decode; reset parks the ALU on a plain ADD.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUCtl  <= CTL_ADD;
            add     <= 1'b0;
            sub     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            ALUCtl  <= ctl_d;
            add     <= add_d;
            sub     <= sub_d;
            illegal <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_ctl.sv
// Self-checking bench for alu_ctl: directed plan plus random
// stimulus against a table-driven reference of the decode rules.
module tb_alu_ctl;

    logic       clk;
    logic       rst;
    logic [1:0] ALUop;
    logic [5:0] func;
    logic [3:0] ALUCtl;
    logic       add;
    logic       sub;
    logic       illegal;

    int tests;
    int failed;

    logic [6:0] exp_q;
    bit         have_exp;
    logic [6:0] dut_out;

    int ctl_tab [64];

    assign dut_out = {ALUCtl, add, sub, illegal};

    alu_ctl dut (
        .clk     (clk),
        .rst     (rst),
        .ALUop   (ALUop),
        .func    (func),
        .ALUCtl  (ALUCtl),
        .add     (add),
        .sub     (sub),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got,
                         input logic [6:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_model(input bit r,
                                             input int op,
                                             input int fn);
        int c;
        bit a;
        bit s;
        bit il;
        a  = 0;
        s  = 0;
        il = 0;
        if (r) begin
            c = 2;
        end else if (op == 0) begin
            c = 2;
            a = 1;
        end else if (op == 1) begin
            c = 6;
            s = 1;
        end else if (op == 2) begin
            c  = ctl_tab[fn];
            il = (c == 15);
            a  = (fn == 32);
            s  = (fn == 34);
        end else begin
            c  = 15;
            il = 1;
        end
        return {c[3:0], a, s, il};
    endfunction

    task automatic step(input bit r, input logic [1:0] op,
                        input logic [5:0] fn, input string tag);
        logic [6:0] inv;
        @(negedge clk);
        rst   = r;
        ALUop = op;
        func  = fn;
        #1;
        if (have_exp)
            check({tag, "_hold"}, dut_out, exp_q);
        @(posedge clk);
        #1;
        exp_q    = ref_model(r, int'(op), int'(fn));
        have_exp = 1;
        check(tag, dut_out, exp_q);
        inv = '0;
        inv[0] = add & sub;
        inv[1] = illegal & ~((ALUCtl == 4'hf) & ~add & ~sub);
        check({tag, "_inv"}, inv, 7'd0);
    endtask

    initial begin
        logic [5:0] valid_fn [9];
        tests    = 0;
        failed   = 0;
        have_exp = 0;
        exp_q    = '0;
        for (int i = 0; i < 64; i++) ctl_tab[i] = 15;
        ctl_tab[32] = 2;
        ctl_tab[33] = 2;
        ctl_tab[34] = 6;
        ctl_tab[35] = 6;
        ctl_tab[36] = 0;
        ctl_tab[37] = 1;
        ctl_tab[38] = 3;
        ctl_tab[39] = 12;
        ctl_tab[42] = 7;
        valid_fn = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36,
                     6'd37, 6'd38, 6'd39, 6'd42};

        rst   = 1'b1;
        ALUop = 2'b10;
        func  = 6'd34;

        step(1, 2'b10, 6'd34, "rst0");
        step(1, 2'b10, 6'd34, "rst1");
        step(0, 2'b10, 6'd34, "rel_sub");

        step(0, 2'b00, 6'd32, "op_lw");
        step(0, 2'b01, 6'd32, "op_beq");

        step(0, 2'b10, 6'd32, "r_add");
        step(0, 2'b10, 6'd34, "r_sub");
        step(0, 2'b10, 6'd36, "r_and");
        step(0, 2'b10, 6'd37, "r_or");
        step(0, 2'b10, 6'd39, "r_nor");
        step(0, 2'b10, 6'd42, "r_slt");
        step(0, 2'b10, 6'd33, "r_addu");
        step(0, 2'b10, 6'd35, "r_subu");
        step(0, 2'b10, 6'd38, "r_xor");

        step(0, 2'b10, 6'd10, "r_bad");
        step(0, 2'b11, 6'd32, "rsvd");

        step(0, 2'b10, 6'd36, "mid_a");
        step(0, 2'b10, 6'd37, "mid_b");
        step(1, 2'b10, 6'd34, "mid_rst");
        step(0, 2'b10, 6'd39, "mid_c");
        step(0, 2'b00, 6'd0,  "mid_d");

        for (int i = 0; i < 400; i++) begin
            bit         r;
            logic [1:0] op;
            logic [5:0] fn;
            r  = ($urandom_range(0, 19) == 0);
            op = 2'($urandom);
            if ($urandom_range(0, 1) == 1)
                fn = valid_fn[$urandom_range(0, 8)];
            else
                fn = 6'($urandom);
            step(r, op, fn, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
